// File: rtl/wheel_enc_capture.sv
// Wheel encoder pulse capture: 2-flop sync, debounce filter, tick counter and
// tick-to-tick period measurement. Period logic is present only with WHEEL_ENC_PERIOD_EN.
module wheel_enc_capture #(
    parameter int unsigned DEB_CYC = 16,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned PER_W   = 24
) (
    input  logic             clk_sys,
    input  logic             rst_sys,
    input  logic             evnt_i,
    input  logic             clr_i,
    output logic             tick_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic [PER_W-1:0] per_o,
    output logic             per_vld_o,
    output logic             stall_o
);

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYC - 1);

    logic [1:0]       sync_q;
    logic             evnt_s;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic [7:0]       deb_cnt_q, deb_cnt_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign evnt_s = sync_q[1];

    // Debounce: a differing level must persist DEB_CYC cycles before it is accepted.
    always_comb begin
        level_d   = level_q;
        deb_cnt_d = deb_cnt_q;
        if (evnt_s == level_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            level_d   = ~level_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 8'd1;
        end
    end

    // The tick is taken one cycle after the filtered level rises.
    assign tick_d = level_q & ~level_dly_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_d) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            sync_q      <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            deb_cnt_q   <= '0;
            tick_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync_q      <= {sync_q[0], evnt_i};
            level_q     <= level_d;
            level_dly_q <= level_q;
            deb_cnt_q   <= deb_cnt_d;
            tick_q      <= tick_d;
            cnt_q       <= cnt_d;
        end
    end

    assign tick_o = tick_q;
    assign cnt_o  = cnt_q;

`ifdef WHEEL_ENC_PERIOD_EN

    typedef enum logic [1:0] {
        ST_UNARM = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } per_st_e;

    localparam logic [PER_W-1:0] PER_MAX = '1;

    per_st_e          state_q, state_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             per_vld_q, per_vld_d;
    logic             stall_q, stall_d;

    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        per_d     = per_q;
        per_vld_d = 1'b0;
        stall_d   = stall_q;
        if (clr_i) begin
            state_d   = ST_UNARM;
            per_cnt_d = '0;
            per_d     = '0;
            stall_d   = 1'b0;
        end else begin
            case (state_q)
                ST_UNARM: begin
                    per_cnt_d = '0;
                    if (tick_d) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick_d) begin
                        per_d     = per_cnt_q + 1'b1;
                        per_vld_d = 1'b1;
                        per_cnt_d = '0;
                    end else begin
                        per_cnt_d = per_cnt_q + 1'b1;
                        if (per_cnt_d == PER_MAX) begin
                            state_d = ST_STALL;
                            stall_d = 1'b1;
                        end
                    end
                end
                ST_STALL: begin
                    // Wheel was stopped: report the saturated period.
                    if (tick_d) begin
                        per_d     = PER_MAX;
                        per_vld_d = 1'b1;
                        per_cnt_d = '0;
                        stall_d   = 1'b0;
                        state_d   = ST_RUN;
                    end
                end
                default: begin
                    state_d   = ST_UNARM;
                    per_cnt_d = '0;
                    stall_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q   <= ST_UNARM;
            per_cnt_q <= '0;
            per_q     <= '0;
            per_vld_q <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            per_q     <= per_d;
            per_vld_q <= per_vld_d;
            stall_q   <= stall_d;
        end
    end

    assign per_o     = per_q;
    assign per_vld_o = per_vld_q;
    assign stall_o   = stall_q;

`else

    assign per_o     = '0;
    assign per_vld_o = 1'b0;
    assign stall_o   = 1'b0;

`endif

endmodule

// File: tb/tb_wheel_enc_capture.sv
// Directed bench for wheel_enc_capture (DEB_CYC=4, CNT_W=4, PER_W=8); period
// expectations follow whether WHEEL_ENC_PERIOD_EN is defined.
module tb_wheel_enc_capture;

    localparam int DEB_CYC = 4;
    localparam int CNT_W   = 4;
    localparam int PER_W   = 8;
`ifdef WHEEL_ENC_PERIOD_EN
    localparam int PER_EN = 1;
`else
    localparam int PER_EN = 0;
`endif

    logic             clk_sys = 1'b0;
    logic             rst_sys;
    logic             evnt_i;
    logic             clr_i;
    logic             tick_o;
    logic [CNT_W-1:0] cnt_o;
    logic [PER_W-1:0] per_o;
    logic             per_vld_o;
    logic             stall_o;

    wheel_enc_capture #(
        .DEB_CYC(DEB_CYC),
        .CNT_W  (CNT_W),
        .PER_W  (PER_W)
    ) dut (
        .clk_sys  (clk_sys),
        .rst_sys  (rst_sys),
        .evnt_i   (evnt_i),
        .clr_i    (clr_i),
        .tick_o   (tick_o),
        .cnt_o    (cnt_o),
        .per_o    (per_o),
        .per_vld_o(per_vld_o),
        .stall_o  (stall_o)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Results of the last pulse()/idle() window
    int p_ticks, p_vlds, p_tick_idx, p_tick_cyc, p_per, p_vld_tick, p_cnt_tick;
    int sum_ticks;
    int i_ticks, stall_seen, stall_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
        cyc++;
    endtask

    // evnt_i high for 'hi' of 'total' cycles; clr_i pulsed on index clr_at (-1 = never).
    task automatic pulse(input int hi, input int total, input int clr_at);
        p_ticks = 0; p_vlds = 0; p_tick_idx = -1; p_tick_cyc = 0;
        p_per = 0; p_vld_tick = 0; p_cnt_tick = 0;
        for (int i = 0; i < total; i++) begin
            evnt_i = (i < hi);
            clr_i  = (i == clr_at);
            step();
            if (tick_o) begin
                p_ticks++;
                p_tick_idx = i;
                p_tick_cyc = cyc;
                p_per      = int'(per_o);
                p_vld_tick = int'(per_vld_o);
                p_cnt_tick = int'(cnt_o);
            end
            if (per_vld_o) p_vlds++;
        end
        evnt_i = 1'b0;
        clr_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        i_ticks = 0; stall_seen = 0; stall_cyc = 0;
        evnt_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            if (tick_o) i_ticks++;
            if (stall_o && stall_seen == 0) begin
                stall_seen = 1;
                stall_cyc  = cyc;
            end
        end
    endtask

    task automatic clear();
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
    endtask

    initial begin
        rst_sys = 1'b1;
        evnt_i  = 1'b0;
        clr_i   = 1'b0;
        repeat (3) step();
        check("rst_tick", tick_o, 0);
        check("rst_cnt", cnt_o, 0);
        check("rst_per", per_o, 0);
        check("rst_vld", per_vld_o, 0);
        check("rst_stall", stall_o, 0);
        rst_sys = 1'b0;
        step();

        // Held-high input: tick exactly after edge DEB_CYC+2, no tick on the fall
        pulse(20, 30, -1);
        check("hold_ticks", p_ticks, 1);
        check("hold_tick_idx", p_tick_idx, DEB_CYC + 2);
        check("hold_cnt_at_tick", p_cnt_tick, 1);
        check("hold_first_vld", p_vlds, 0);
        check("hold_cnt", cnt_o, 1);
        clear();
        check("clr_cnt", cnt_o, 0);
        check("clr_per", per_o, 0);

        // Short glitches are filtered
        sum_ticks = 0;
        for (int k = 0; k < 5; k++) begin
            pulse(3, 10, -1);
            sum_ticks += p_ticks;
        end
        check("glitch_ticks", sum_ticks, 0);
        check("glitch_cnt", cnt_o, 0);

        // Pulses every 100 cycles
        pulse(10, 100, -1);
        check("p100_1_ticks", p_ticks, 1);
        check("p100_1_vld", p_vlds, 0);
        check("p100_1_cnt", cnt_o, 1);
        for (int k = 2; k <= 3; k++) begin
            pulse(10, 100, -1);
            check("p100_ticks", p_ticks, 1);
            check("p100_vld_at_tick", p_vld_tick, PER_EN);
            check("p100_vld_count", p_vlds, PER_EN);
            check("p100_per", p_per, PER_EN * 100);
            check("p100_cnt", cnt_o, k);
        end
        check("p100_per_hold", per_o, PER_EN * 100);

        // Stall after 255 idle cycles, then saturated period reported
        pulse(10, 10, -1);
        check("stall_pre_tick", p_ticks, 1);
        idle(300);
        check("stall_seen", stall_seen, PER_EN);
        check("stall_delay", stall_seen != 0 ? stall_cyc - p_tick_cyc : 0, PER_EN * 255);
        check("stall_level", stall_o, PER_EN);
        pulse(10, 100, -1);
        check("stall_tick_vld", p_vld_tick, PER_EN);
        check("stall_tick_per", p_per, PER_EN * 255);
        check("stall_cleared", stall_o, 0);

        // Counter wrap at CNT_W=4
        clear();
        sum_ticks = 0;
        for (int k = 0; k < 17; k++) begin
            pulse(10, 20, -1);
            sum_ticks += p_ticks;
        end
        check("wrap_ticks", sum_ticks, 17);
        check("wrap_cnt", cnt_o, 1);

        // clr coincident with a tick: clear wins, tick still pulses
        pulse(10, 20, DEB_CYC + 2);
        check("clrtick_ticks", p_ticks, 1);
        check("clrtick_cnt", p_cnt_tick, 0);
        check("clrtick_vld", p_vlds, 0);
        check("clrtick_per", per_o, 0);
        pulse(10, 20, -1);
        check("after_clr_vld", p_vlds, 0);
        check("after_clr_cnt", cnt_o, 1);

        // Reset during debounce and during a period measurement
        pulse(10, 20, -1);
        check("pre_rst_per", per_o, PER_EN * 20);
        evnt_i = 1'b1;
        repeat (3) step();
        rst_sys = 1'b1;
        evnt_i  = 1'b0;
        repeat (2) step();
        rst_sys = 1'b0;
        idle(15);
        check("rst_mid_ticks", i_ticks, 0);
        check("rst_mid_cnt", cnt_o, 0);
        check("rst_mid_per", per_o, 0);
        check("rst_mid_stall", stall_o, 0);
        pulse(10, 100, -1);
        check("post_rst_vld", p_vlds, 0);
        check("post_rst_cnt", cnt_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
